// File: rtl/dram_host_bridge.sv
// DRAM-side data memory for the processor: loads operands from a host byte stream,
// hands the RAM to the processor for a run, then streams a result window back out.
module dram_host_bridge #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 8
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              host_load_start,
    input  logic [ADDR_W-1:0] host_load_len,
    input  logic [ADDR_W-1:0] dump_base,
    input  logic [ADDR_W-1:0] dump_len,
    input  logic              host_in_valid,
    input  logic [WIDTH-1:0]  host_in_data,
    output logic              host_in_ready,
    output logic              host_out_valid,
    output logic [WIDTH-1:0]  host_out_data,
    input  logic              host_out_ready,
    output logic              proc_start,
    input  logic              proc_done,
    input  logic              memREAD,
    input  logic              memWRITE,
    input  logic [ADDR_W-1:0] DRAM_addr,
    input  logic [WIDTH-1:0]  DRAM_dataOut,
    output logic [WIDTH-1:0]  DRAM_dataIn,
    output logic              busy,
    output logic              xfer_done,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        RUN   = 3'd3,
        DUMP  = 3'd4,
        FIN   = 3'd5
    } state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0]  mem [0:(1<<ADDR_W)-1];

    logic [ADDR_W-1:0] len_q, base_q, dlen_q;
    logic [ADDR_W-1:0] wr_ptr, rd_ptr, issue_left, remaining;
    logic [ADDR_W-1:0] last_idx;

    logic              rd_vld;
    logic [WIDTH-1:0]  rd_q;
    logic [WIDTH-1:0]  obuf [0:1];
    logic              head, tail;
    logic [1:0]        count;
    logic [2:0]        occ;

    logic              load_beat, run_wr, run_rd, pop, issue;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WIDTH-1:0]  mem_wdata;

    // Both host streams: a word moves on a rising edge where valid && ready are high;
    // the source holds valid and data stable until that edge, ready may drop at any time.
    always_comb begin
        state_nx       = state;
        host_in_ready  = 1'b0;
        host_out_valid = 1'b0;
        proc_start     = 1'b0;
        xfer_done      = 1'b0;
        case (state)
            IDLE: begin
                if (host_load_start)
                    state_nx = (host_load_len != '0) ? LOAD : START;
            end
            LOAD: begin
                host_in_ready = 1'b1;
                if (host_in_valid && wr_ptr == last_idx)
                    state_nx = START;
            end
            START: begin
                proc_start = 1'b1;
                state_nx   = RUN;
            end
            RUN: begin
                if (proc_done)
                    state_nx = (dlen_q != '0) ? DUMP : FIN;
            end
            DUMP: begin
                host_out_valid = (count != 2'd0);
                if (host_out_valid && host_out_ready && remaining == ADDR_W'(1))
                    state_nx = FIN;
            end
            FIN: begin
                xfer_done = 1'b1;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy          = (state != IDLE);
    assign state_dbg     = state;
    assign host_out_data = obuf[head];
    assign last_idx      = len_q - ADDR_W'(1);

    assign load_beat = host_in_ready && host_in_valid;
    assign run_wr    = (state == RUN) && memWRITE;
    assign run_rd    = (state == RUN) && memREAD && !memWRITE;
    assign pop       = host_out_valid && host_out_ready;

    // Occupancy the buffer will have once this edge settles; a read issued now lands
    // one edge later, so it may only go out if at least one slot stays free.
    assign occ   = {1'b0, count} + {2'b00, rd_vld} - {2'b00, pop};
    assign issue = (state == DUMP) && (issue_left != '0) && (occ <= 3'd1);

    assign mem_we    = !Rst && (load_beat || run_wr);
    assign mem_addr  = load_beat ? wr_ptr : DRAM_addr;
    assign mem_wdata = load_beat ? host_in_data : DRAM_dataOut;

    always_ff @(posedge Clk) begin
        if (mem_we)
            mem[mem_addr] <= mem_wdata;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state       <= IDLE;
            len_q       <= '0;
            base_q      <= '0;
            dlen_q      <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            issue_left  <= '0;
            remaining   <= '0;
            rd_vld      <= 1'b0;
            rd_q        <= '0;
            obuf[0]     <= '0;
            obuf[1]     <= '0;
            head        <= 1'b0;
            tail        <= 1'b0;
            count       <= 2'd0;
            DRAM_dataIn <= '0;
        end else begin
            state <= state_nx;

            if (state == IDLE && host_load_start) begin
                len_q  <= host_load_len;
                base_q <= dump_base;
                dlen_q <= dump_len;
                wr_ptr <= '0;
            end

            if (load_beat)
                wr_ptr <= wr_ptr + ADDR_W'(1);

            if (run_rd)
                DRAM_dataIn <= mem[DRAM_addr];

            if (state == RUN && proc_done) begin
                rd_ptr     <= base_q;
                issue_left <= dlen_q;
                remaining  <= dlen_q;
                rd_vld     <= 1'b0;
                head       <= 1'b0;
                tail       <= 1'b0;
                count      <= 2'd0;
            end else begin
                rd_vld <= issue;
                if (issue) begin
                    rd_q       <= mem[rd_ptr];
                    rd_ptr     <= rd_ptr + ADDR_W'(1);
                    issue_left <= issue_left - ADDR_W'(1);
                end
                if (rd_vld) begin
                    obuf[tail] <= rd_q;
                    tail       <= ~tail;
                end
                if (pop) begin
                    head      <= ~head;
                    remaining <= remaining - ADDR_W'(1);
                end
                count <= count + {1'b0, rd_vld} - {1'b0, pop};
            end
        end
    end

endmodule

// File: tb/tb_dram_host_bridge.sv
// Directed bench for dram_host_bridge: a RAM/queue model of the bridge checked every
// cycle, plus hand-computed literal expectations for load, run access and dumps.
module tb_dram_host_bridge;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       host_load_start;
  logic [7:0] host_load_len, dump_base, dump_len;
  logic       host_in_valid;
  logic [7:0] host_in_data;
  logic       host_in_ready;
  logic       host_out_valid;
  logic [7:0] host_out_data;
  logic       host_out_ready;
  logic       proc_start;
  logic       proc_done;
  logic       memREAD, memWRITE;
  logic [7:0] DRAM_addr, DRAM_dataOut, DRAM_dataIn;
  logic       busy, xfer_done;
  logic [2:0] state_dbg;

  dram_host_bridge #(.WIDTH(8), .ADDR_W(8)) dut (
    .Clk(Clk), .Rst(Rst),
    .host_load_start(host_load_start), .host_load_len(host_load_len),
    .dump_base(dump_base), .dump_len(dump_len),
    .host_in_valid(host_in_valid), .host_in_data(host_in_data), .host_in_ready(host_in_ready),
    .host_out_valid(host_out_valid), .host_out_data(host_out_data), .host_out_ready(host_out_ready),
    .proc_start(proc_start), .proc_done(proc_done),
    .memREAD(memREAD), .memWRITE(memWRITE), .DRAM_addr(DRAM_addr),
    .DRAM_dataOut(DRAM_dataOut), .DRAM_dataIn(DRAM_dataIn),
    .busy(busy), .xfer_done(xfer_done), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 Clk = ~Clk;

  // model state
  int         total = 0;
  int         bad = 0;
  int         n_start = 0;
  int         n_done = 0;
  logic [7:0] ref_mem [256];
  logic [7:0] exp_q [$];
  logic [7:0] got_q [$];
  logic [7:0] exp_dram_in = 8'h00;
  bit         in_run = 0;
  int         load_idx = 0;
  logic [7:0] cur_base = 8'h00;
  logic [7:0] cur_dlen = 8'h00;
  bit         prev_stall = 0;
  logic [7:0] prev_data = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // driver tasks
  task automatic cmd(input logic [7:0] len, input logic [7:0] base, input logic [7:0] dlen);
    host_load_start = 1'b1;
    host_load_len   = len;
    dump_base       = base;
    dump_len        = dlen;
    tick();
    host_load_start = 1'b0;
    load_idx = 0;
    cur_base = base;
    cur_dlen = dlen;
  endtask

  task automatic load_bytes(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input int n, input bit gap);
    logic [7:0] bytes [4];
    int w;
    bytes = '{b0, b1, b2, b3};
    for (int k = 0; k < n; k++) begin
      if (gap) begin
        host_in_valid = 1'b0;
        tick();
      end
      host_in_valid = 1'b1;
      host_in_data  = bytes[k];
      w = 0;
      while (!host_in_ready && w < 20) begin
        tick();
        w++;
      end
      if (!host_in_ready) chk("load_ready_timeout", host_in_ready, 1);
      tick();
      ref_mem[load_idx[7:0]] = bytes[k];
      load_idx++;
    end
    host_in_valid = 1'b0;
  endtask

  task automatic proc_write(input logic [7:0] a, input logic [7:0] d);
    memWRITE = 1'b1; DRAM_addr = a; DRAM_dataOut = d;
    tick();
    if (in_run) ref_mem[a] = d;
    memWRITE = 1'b0;
  endtask

  task automatic proc_read(input logic [7:0] a);
    memREAD = 1'b1; DRAM_addr = a;
    tick();
    if (in_run) exp_dram_in = ref_mem[a];
    memREAD = 1'b0;
  endtask

  task automatic proc_rw(input logic [7:0] a, input logic [7:0] d);
    memREAD = 1'b1; memWRITE = 1'b1; DRAM_addr = a; DRAM_dataOut = d;
    tick();
    if (in_run) ref_mem[a] = d;
    memREAD = 1'b0; memWRITE = 1'b0;
  endtask

  task automatic finish_run();
    logic [7:0] a;
    proc_done = 1'b1;
    tick();
    proc_done = 1'b0;
    in_run = 0;
    for (int i = 0; i < int'(cur_dlen); i++) begin
      a = cur_base + 8'(i);
      exp_q.push_back(ref_mem[a]);
    end
  endtask

  task automatic run_dump(input bit p0, input bit p1, input bit p2, input bit p3);
    bit pat [4];
    int cyc;
    pat = '{p0, p1, p2, p3};
    got_q.delete();
    cyc = 0;
    while (cyc < 100) begin
      host_out_ready = pat[cyc % 4];
      tick();
      cyc++;
      if (xfer_done) break;
    end
    chk("xfer_done_seen", xfer_done, 1);
    host_out_ready = 1'b0;
    tick();
    chk("idle_after_fin", busy, 0);
  endtask

  // scoreboard / compare process
  always @(negedge Clk) begin
    if (!Rst) begin
      chk("dram_dataIn", DRAM_dataIn, exp_dram_in);
      if (prev_stall) begin
        chk("stall_valid", host_out_valid, 1);
        chk("stall_data", host_out_data, prev_data);
      end
      if (host_out_valid && host_out_ready) begin
        if (exp_q.size() == 0) chk("dump_unexpected_word", host_out_valid, 0);
        else chk("dump_data", host_out_data, exp_q.pop_front());
        got_q.push_back(host_out_data);
      end
      prev_stall = host_out_valid && !host_out_ready;
      prev_data  = host_out_data;
      if (proc_start) n_start++;
      if (xfer_done) n_done++;
    end else begin
      prev_stall = 0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, d0;
    Rst = 1'b1;
    host_load_start = 0; host_load_len = 0; dump_base = 0; dump_len = 0;
    host_in_valid = 0; host_in_data = 0; host_out_ready = 0; proc_done = 0;
    memREAD = 0; memWRITE = 0; DRAM_addr = 0; DRAM_dataOut = 0;
    tick();
    tick();
    chk("rst_in_ready", host_in_ready, 0);
    chk("rst_out_valid", host_out_valid, 0);
    chk("rst_proc_start", proc_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_xfer_done", xfer_done, 0);
    chk("rst_out_data", host_out_data, 8'h00);
    chk("rst_dataIn", DRAM_dataIn, 8'h00);
    chk("rst_state", state_dbg, 3'd0);
    Rst = 1'b0;
    tick();

    // load 4 bytes with valid gapped every other cycle
    cmd(8'd4, 8'h80, 8'd3);
    chk("load_ready", host_in_ready, 1);
    chk("load_busy", busy, 1);
    s0 = n_start;
    load_bytes(8'h11, 8'h22, 8'h33, 8'h44, 4, 1);
    chk("start_after_last_beat", proc_start, 1);
    chk("in_ready_dropped", host_in_ready, 0);
    in_run = 1;
    tick();
    chk("start_one_cycle", proc_start, 0);
    chk("start_pulse_count", n_start - s0, 1);

    // processor access during RUN
    proc_write(8'h80, 8'hA5);
    proc_write(8'h81, 8'hB6);
    proc_write(8'h82, 8'hC7);
    proc_read(8'h80);
    chk("read_80", DRAM_dataIn, 8'hA5);
    proc_read(8'h02);
    chk("read_loaded_02", DRAM_dataIn, 8'h33);
    proc_rw(8'h02, 8'h5A);
    chk("rw_holds_dataIn", DRAM_dataIn, 8'h33);
    proc_read(8'h02);
    chk("rw_wrote_02", DRAM_dataIn, 8'h5A);
    proc_read(8'h01);
    chk("read_loaded_01", DRAM_dataIn, 8'h22);
    proc_read(8'h00);
    chk("read_loaded_00", DRAM_dataIn, 8'h11);

    // back-pressured dump of 0x80..0x82
    host_out_ready = 1'b0;
    d0 = n_done;
    finish_run();
    run_dump(1, 0, 0, 1);
    chk("bp_count", got_q.size(), 3);
    if (got_q.size() == 3) begin
      chk("bp_word0", got_q[0], 8'hA5);
      chk("bp_word1", got_q[1], 8'hB6);
      chk("bp_word2", got_q[2], 8'hC7);
    end
    chk("bp_all_delivered", exp_q.size(), 0);
    chk("bp_xfer_pulses", n_done - d0, 1);

    // processor requests in IDLE are ignored
    proc_write(8'h03, 8'hEE);
    proc_read(8'h03);
    chk("idle_read_ignored", DRAM_dataIn, 8'h11);

    // len=0 goes straight to START; wrapped dump with ready held high
    cmd(8'd0, 8'hFE, 8'd3);
    chk("len0_start", proc_start, 1);
    in_run = 1;
    tick();
    chk("len0_start_one_cycle", proc_start, 0);
    proc_write(8'hFE, 8'h01);
    proc_write(8'hFF, 8'h02);
    proc_read(8'h03);
    chk("idle_write_ignored", DRAM_dataIn, 8'h44);
    host_out_ready = 1'b1;
    finish_run();
    chk("wrap_lat_c0", host_out_valid, 0);
    tick();
    chk("wrap_lat_c1", host_out_valid, 0);
    tick();
    chk("wrap_c2_valid", host_out_valid, 1);
    chk("wrap_c2_data", host_out_data, 8'h01);
    tick();
    chk("wrap_c3_valid", host_out_valid, 1);
    chk("wrap_c3_data", host_out_data, 8'h02);
    tick();
    chk("wrap_c4_valid", host_out_valid, 1);
    chk("wrap_c4_data", host_out_data, 8'h11);
    tick();
    chk("wrap_xfer_done", xfer_done, 1);
    chk("wrap_valid_off", host_out_valid, 0);
    host_out_ready = 1'b0;
    tick();
    chk("wrap_idle", busy, 0);
    chk("wrap_all_delivered", exp_q.size(), 0);

    // reset in the middle of a load
    cmd(8'd4, 8'h00, 8'd3);
    load_bytes(8'h61, 8'h62, 8'h00, 8'h00, 2, 0);
    chk("midload_ready", host_in_ready, 1);
    Rst = 1'b1;
    exp_dram_in = 8'h00;
    host_in_valid = 1'b1;
    host_in_data  = 8'h77;
    tick();
    chk("midload_rst_busy", busy, 0);
    chk("midload_rst_ready", host_in_ready, 0);
    chk("midload_rst_state", state_dbg, 3'd0);
    host_in_valid = 1'b0;
    Rst = 1'b0;
    tick();

    // words written before the reset survive; the beat under reset did not write
    cmd(8'd0, 8'h00, 8'd3);
    chk("retain_start", proc_start, 1);
    in_run = 1;
    tick();
    finish_run();
    run_dump(1, 1, 0, 1);
    chk("retain_count", got_q.size(), 3);
    if (got_q.size() == 3) begin
      chk("retain_word0", got_q[0], 8'h61);
      chk("retain_word1", got_q[1], 8'h62);
      chk("retain_word2", got_q[2], 8'h5A);
    end
    chk("retain_all_delivered", exp_q.size(), 0);
    chk("start_total", n_start, 3);
    chk("xfer_total", n_done, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
